// File: rtl/branch_resolve_stage.sv
// -----------------------------------------------------------------------------
// branch_resolve_stage
//
// Sits directly behind the ALU comparator. For every accepted instruction it
// makes the register writeback decision (ALU, conditional move, link), resolves
// branches and jumps, and sequences the architectural delay slot before issuing
// a single-cycle PC redirect to fetch. It also keeps saturating statistics of
// branches seen and branches taken.
//
// Parameters
//   RESET_PC  value driven on redirect_pc out of reset
//   CNT_W     width of the saturating statistics counters
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready  upstream handshake; in_ready depends on state only
//   op                  class: 0 ALU, 1 branch, 2 branch-and-link,
//                       3 conditional move, 4 jump, 5-7 behave as ALU
//   cond_flag           comparator flag, only bit 0 is used
//   result, rd          writeback data and destination register
//   pc, offset          instruction address and branch word offset
//   wb_en/addr/data     registered register-file write, one cycle per accept
//   redirect_valid/pc   registered one-cycle fetch redirect
//   branch_cnt          branches/jumps accepted outside a delay slot
//   taken_cnt           those of them that were taken
// -----------------------------------------------------------------------------
module branch_resolve_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [3:0]       cond_flag,
    input  logic [31:0]      result,
    input  logic [4:0]       rd,
    input  logic [31:0]      pc,
    input  logic [15:0]      offset,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    // SLOT_WB is the cycle in which the delay slot's writeback is presented;
    // the redirect follows it so that fetch never sees the redirect before the
    // slot has retired.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SLOT,
        S_SLOT_WB,
        S_REDIR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t      state, state_next;
    logic [31:0] pending_pc;

    logic        accept;
    logic        is_branch, is_link, is_cmov, is_jump, is_transfer, is_taken;
    logic        count_transfer;
    logic [31:0] target;

    logic        sel_en;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    assign in_ready = (state == S_IDLE) || (state == S_SLOT);
    assign accept   = in_valid && in_ready;

    // Decode; classes 5-7 fall through to the ALU writeback path.
    assign is_branch   = (op == 3'd1) || (op == 3'd2);
    assign is_link     = (op == 3'd2);
    assign is_cmov     = (op == 3'd3);
    assign is_jump     = (op == 3'd4);
    assign is_transfer = is_branch || is_jump;
    assign is_taken    = is_jump || (is_branch && cond_flag[0]);

    // Wraps silently modulo 2^32.
    assign target = pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};

    // Only transfers accepted in IDLE are real; one sitting in a delay slot
    // neither redirects nor counts.
    assign count_transfer = accept && is_transfer && (state == S_IDLE);

    // Writeback selection.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel_en   = 1'b0;
        sel_addr = rd;
        sel_data = result;
        if (is_link) begin
            sel_en   = 1'b1;
            sel_addr = 5'd31;
            sel_data = pc + 32'd8;
        end else if (is_cmov) begin
            sel_en   = cond_flag[0];
        end else if (!is_transfer) begin
            sel_en   = 1'b1;
        end
        // Register 0 is hard-wired; never write it.
        if (sel_addr == 5'd0) begin
            sel_en = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:    if (accept && is_taken) state_next = S_SLOT;
            S_SLOT:    if (accept)             state_next = S_SLOT_WB;
            S_SLOT_WB:                         state_next = S_REDIR;
            S_REDIR:                           state_next = S_IDLE;
            default:                           state_next = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending target is captured only for a taken transfer outside a slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_pc <= 32'd0;
        end else if (count_transfer && is_taken) begin
            pending_pc <= target;
        end
    end

    // Writeback outputs: strobe lasts one cycle, address/data follow accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_en   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
        end else begin
            wb_en <= accept && sel_en;
            if (accept) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    // Redirect outputs: redirect_pc holds its value outside the redirect cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            redirect_valid <= (state_next == S_REDIR);
            if (state_next == S_REDIR) begin
                redirect_pc <= pending_pc;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (count_transfer) begin
            if (branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (is_taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_stage.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_stage
//
// Directed bench for branch_resolve_stage with CNT_W=4 so counter saturation is
// reachable. Inputs change 1 ns after a rising edge; outputs are sampled at the
// same point, i.e. they show the effect of the edge just passed.
// -----------------------------------------------------------------------------
module tb_branch_resolve_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [3:0]       cond_flag;
    logic [31:0]      result;
    logic [4:0]       rd;
    logic [31:0]      pc;
    logic [15:0]      offset;
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    branch_resolve_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .cond_flag      (cond_flag),
        .result         (result),
        .rd             (rd),
        .pc             (pc),
        .offset         (offset),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .taken_cnt      (taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction for exactly one edge, then drop in_valid.
    task automatic issue(input logic [2:0] i_op, input logic i_cond, input logic [31:0] i_result,
                         input logic [4:0] i_rd, input logic [31:0] i_pc, input logic [15:0] i_offset);
        in_valid  = 1'b1;
        op        = i_op;
        cond_flag = {3'b101, i_cond};
        result    = i_result;
        rd        = i_rd;
        pc        = i_pc;
        offset    = i_offset;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held while upstream offers an ALU write to r5.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd0;
        cond_flag = 4'd0;
        result    = 32'h1111_2222;
        rd        = 5'd5;
        pc        = 32'd0;
        offset    = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wb_en", {31'd0, wb_en}, 32'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("reset_redirect_pc", redirect_pc, 32'h0000_0000);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        check("reset_taken_cnt", {28'd0, taken_cnt}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // ALU writeback, then conditional moves back to back.
        issue(3'd0, 1'b0, 32'hDEAD_BEEF, 5'd3, 32'h0, 16'h0);
        check("alu_wb_en", {31'd0, wb_en}, 32'd1);
        check("alu_wb_addr", {27'd0, wb_addr}, 32'd3);
        check("alu_wb_data", wb_data, 32'hDEAD_BEEF);
        issue(3'd3, 1'b0, 32'h0000_0055, 5'd6, 32'h0, 16'h0);
        check("movz_false_wb_en", {31'd0, wb_en}, 32'd0);
        issue(3'd3, 1'b1, 32'h0000_0066, 5'd0, 32'h0, 16'h0);
        check("cmov_r0_wb_en", {31'd0, wb_en}, 32'd0);
        issue(3'd3, 1'b1, 32'h0000_0077, 5'd7, 32'h0, 16'h0);
        check("cmov_true_wb_en", {31'd0, wb_en}, 32'd1);
        check("cmov_true_wb_data", wb_data, 32'h0000_0077);
        issue(3'd6, 1'b0, 32'h0000_0088, 5'd8, 32'h0, 16'h0);
        check("op6_as_alu_wb_addr", {27'd0, wb_addr}, 32'd8);
        idle(1);
        check("wb_one_cycle", {31'd0, wb_en}, 32'd0);

        // Taken branch 0x100 + 4 - 4 = 0x100, delay slot writes r4.
        issue(3'd1, 1'b1, 32'h0, 5'd9, 32'h0000_0100, 16'hFFFF);
        check("br_no_wb", {31'd0, wb_en}, 32'd0);
        check("br_slot_in_ready", {31'd0, in_ready}, 32'd1);
        issue(3'd0, 1'b0, 32'h0000_1234, 5'd4, 32'h0000_0104, 16'h0);
        check("slot_wb_en", {31'd0, wb_en}, 32'd1);
        check("slot_wb_addr", {27'd0, wb_addr}, 32'd4);
        check("slot_wb_data", wb_data, 32'h0000_1234);
        check("slot_no_redirect_yet", {31'd0, redirect_valid}, 32'd0);
        idle(1);
        check("br_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("br_redirect_pc", redirect_pc, 32'h0000_0100);
        check("br_redirect_in_ready", {31'd0, in_ready}, 32'd0);
        idle(1);
        check("br_redirect_one_cycle", {31'd0, redirect_valid}, 32'd0);
        check("br_redirect_pc_hold", redirect_pc, 32'h0000_0100);
        check("br_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("br_branch_cnt", {28'd0, branch_cnt}, 32'd1);
        check("br_taken_cnt", {28'd0, taken_cnt}, 32'd1);

        // Not-taken branch-and-link: link written, no redirect, no bubble.
        issue(3'd2, 1'b0, 32'h0, 5'd12, 32'h0000_2000, 16'h0010);
        check("bal_nt_wb_en", {31'd0, wb_en}, 32'd1);
        check("bal_nt_wb_addr", {27'd0, wb_addr}, 32'd31);
        check("bal_nt_wb_data", wb_data, 32'h0000_2008);
        check("bal_nt_in_ready", {31'd0, in_ready}, 32'd1);
        issue(3'd0, 1'b0, 32'h0000_00AA, 5'd10, 32'h0000_2004, 16'h0);
        check("bal_nt_zero_bubble", {27'd0, wb_addr}, 32'd10);
        check("bal_nt_no_redirect", {31'd0, redirect_valid}, 32'd0);
        check("bal_nt_branch_cnt", {28'd0, branch_cnt}, 32'd2);
        check("bal_nt_taken_cnt", {28'd0, taken_cnt}, 32'd1);

        // Jump whose target wraps: 0xFFFF_FFF8 + 4 + 4 = 0.
        issue(3'd4, 1'b0, 32'h0, 5'd0, 32'hFFFF_FFF8, 16'h0001);
        issue(3'd0, 1'b0, 32'h0000_00BB, 5'd0, 32'hFFFF_FFFC, 16'h0);
        check("jmp_slot_r0_no_wb", {31'd0, wb_en}, 32'd0);
        idle(1);
        check("wrap_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("wrap_redirect_pc", redirect_pc, 32'h0000_0000);
        idle(1);
        check("wrap_branch_cnt", {28'd0, branch_cnt}, 32'd3);
        check("wrap_taken_cnt", {28'd0, taken_cnt}, 32'd2);

        // Taken branch, 5-cycle stall in SLOT; target 0x404 + 0x40 = 0x444.
        // The slot holds a taken branch-and-link: link only, no count.
        issue(3'd1, 1'b1, 32'h0, 5'd0, 32'h0000_0400, 16'h0010);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
        end
        check("stall_in_ready", {31'd0, in_ready}, 32'd1);
        issue(3'd2, 1'b1, 32'h0, 5'd0, 32'h0000_0800, 16'h0100);
        check("slot_link_wb_en", {31'd0, wb_en}, 32'd1);
        check("slot_link_wb_data", wb_data, 32'h0000_0808);
        idle(1);
        check("stall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("stall_redirect_pc", redirect_pc, 32'h0000_0444);
        idle(1);
        check("slot_br_not_counted", {28'd0, branch_cnt}, 32'd4);
        check("slot_br_not_taken_cnt", {28'd0, taken_cnt}, 32'd3);

        // Taken jump, then reset while waiting in SLOT.
        issue(3'd4, 1'b0, 32'h0, 5'd0, 32'h0000_1000, 16'h0000);
        idle(2);
        reset_n = 1'b0;
        #2;
        check("midreset_redirect_pc", redirect_pc, 32'h0000_0000);
        check("midreset_branch_cnt", {28'd0, branch_cnt}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
        issue(3'd0, 1'b0, 32'h0000_00CC, 5'd2, 32'h0000_1004, 16'h0);
        check("midreset_alu_wb", wb_data, 32'h0000_00CC);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("midreset_no_redirect", {31'd0, redirect_valid}, 32'd0);
        end

        // Saturation: 20 taken jumps, each with its delay slot.
        for (int i = 0; i < 20; i++) begin
            issue(3'd4, 1'b0, 32'h0, 5'd0, 32'h0000_3000 + 32'(i * 16), 16'h0004);
            issue(3'd0, 1'b0, 32'h0, 5'd1, 32'h0000_3004 + 32'(i * 16), 16'h0);
            idle(2);
        end
        check("sat_branch_cnt", {28'd0, branch_cnt}, 32'h0000_000F);
        check("sat_taken_cnt", {28'd0, taken_cnt}, 32'h0000_000F);
        issue(3'd1, 1'b0, 32'h0, 5'd0, 32'h0000_4000, 16'h0);
        idle(1);
        check("sat_branch_cnt_held", {28'd0, branch_cnt}, 32'h0000_000F);
        check("sat_taken_cnt_held", {28'd0, taken_cnt}, 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
